// File: rtl/helios_single_fpga.sv
// Byte-stream surface-code syndrome decoder: arm, load one measurement frame, cluster
// defects by min-root propagation, return a status/correction frame. Option: HELIOS_CYCLE_COUNTER_EN.
module helios_single_fpga #(
  parameter int unsigned GRID_WIDTH_X            = 4,
  parameter int unsigned GRID_WIDTH_Z            = 2,
  parameter int unsigned GRID_WIDTH_U            = 3,
  parameter int unsigned MAX_WEIGHT              = 2,
  parameter logic [7:0]  START_DECODING_MSG      = 8'h01,
  parameter logic [7:0]  MEASUREMENT_DATA_HEADER = 8'h02
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] input_data,
  input  logic       input_valid,
  output logic       input_ready,
  output logic [7:0] output_data,
  output logic       output_valid,
  input  logic       output_ready
);

  localparam int unsigned N          = GRID_WIDTH_X * GRID_WIDTH_Z;
  localparam int unsigned B          = (N + 7) / 8;
  localparam int unsigned A          = 8 * B;
  localparam int unsigned NODES      = N * GRID_WIDTH_U;
  localparam int unsigned MEAS_W     = A * GRID_WIDTH_U;
  localparam int unsigned LOAD_BYTES = B * GRID_WIDTH_U;
  localparam int unsigned RW         = (NODES > 1) ? $clog2(NODES) : 1;
  localparam int unsigned BCW        = (LOAD_BYTES > 1) ? $clog2(LOAD_BYTES + 1) : 1;
  localparam int unsigned FRAME_LEN  = 3 + GRID_WIDTH_U;
  localparam int unsigned SW         = $clog2(FRAME_LEN + 1);

  localparam logic [2:0] S_WAIT_START = 3'd0;
  localparam logic [2:0] S_IDLE       = 3'd1;
  localparam logic [2:0] S_LOAD       = 3'd2;
  localparam logic [2:0] S_INIT       = 3'd3;
  localparam logic [2:0] S_ITERATE    = 3'd4;
  localparam logic [2:0] S_SEND       = 3'd5;

  logic [2:0]        state_q, state_d;
  logic [MEAS_W-1:0] meas_q;
  logic [BCW-1:0]    byte_cnt_q;
  logic [RW-1:0]     root_q   [NODES];
  logic [RW-1:0]     new_root [NODES];
  logic [7:0]        iter_q;
  logic [SW-1:0]     send_idx_q;
  logic [NODES-1:0]  defect;
  logic [7:0]        root_cnt [GRID_WIDTH_U];
  logic [7:0]        frame_byte;
  logic              changed;
  logic              accept_in;
  logic              out_free;
`ifdef HELIOS_CYCLE_COUNTER_EN
  logic [15:0]       cyc_q;
`endif

  // Two nodes are linked when their grid Manhattan distance is within MAX_WEIGHT
  function automatic logic linked(input int unsigned a, input int unsigned b);
    int unsigned ax, az, au, bx, bz, bu, d;
    au = a / N;  ax = (a % N) / GRID_WIDTH_Z;  az = (a % N) % GRID_WIDTH_Z;
    bu = b / N;  bx = (b % N) / GRID_WIDTH_Z;  bz = (b % N) % GRID_WIDTH_Z;
    d  = ((ax > bx) ? ax - bx : bx - ax) + ((az > bz) ? az - bz : bz - az)
       + ((au > bu) ? au - bu : bu - au);
    return d <= MAX_WEIGHT;
  endfunction

  assign accept_in = input_valid && input_ready;
  assign out_free  = !output_valid || output_ready;

  always_comb begin
    for (int i = 0; i < NODES; i++) defect[i] = meas_q[(i % N) + (i / N) * A];
  end

  // One propagation step: each defect takes the minimum root among linked defects
  always_comb begin
    changed = 1'b0;
    for (int i = 0; i < NODES; i++) begin
      new_root[i] = root_q[i];
      for (int j = 0; j < NODES; j++) begin
        if (defect[i] && defect[j] && linked(i, j) && (root_q[j] < new_root[i]))
          new_root[i] = root_q[j];
      end
      if (new_root[i] != root_q[i]) changed = 1'b1;
    end
  end

  // Cluster roots per round
  always_comb begin
    int unsigned cnt;
    for (int u = 0; u < GRID_WIDTH_U; u++) begin
      cnt = 0;
      for (int r = 0; r < N; r++) begin
        if (defect[u*N + r] && (root_q[u*N + r] == RW'(u*N + r))) cnt = cnt + 1;
      end
      root_cnt[u] = (cnt > 32'd255) ? 8'hFF : 8'(cnt);
    end
  end

  always_comb begin
    frame_byte = 8'h00;
    if (send_idx_q == SW'(0)) frame_byte = iter_q;
`ifdef HELIOS_CYCLE_COUNTER_EN
    if (send_idx_q == SW'(1)) frame_byte = cyc_q[15:8];
    if (send_idx_q == SW'(2)) frame_byte = cyc_q[7:0];
`endif
    for (int u = 0; u < GRID_WIDTH_U; u++) begin
      if (send_idx_q == SW'(3 + u)) frame_byte = root_cnt[u];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_START: if (accept_in && input_data == START_DECODING_MSG) state_d = S_IDLE;
      S_IDLE:       if (accept_in && input_data == MEASUREMENT_DATA_HEADER) state_d = S_LOAD;
      S_LOAD:       if (accept_in && byte_cnt_q == BCW'(LOAD_BYTES - 1)) state_d = S_INIT;
      S_INIT:       state_d = S_ITERATE;
      S_ITERATE:    if (!changed) state_d = S_SEND;
      S_SEND:       if (out_free && send_idx_q == SW'(FRAME_LEN)) state_d = S_IDLE;
      default:      state_d = S_WAIT_START;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_WAIT_START;
      input_ready  <= 1'b0;
      output_valid <= 1'b0;
      output_data  <= 8'h00;
      meas_q       <= '0;
      byte_cnt_q   <= '0;
      iter_q       <= 8'h00;
      send_idx_q   <= '0;
      for (int i = 0; i < NODES; i++) root_q[i] <= '0;
`ifdef HELIOS_CYCLE_COUNTER_EN
      cyc_q        <= 16'h0000;
`endif
    end else begin
      state_q     <= state_d;
      input_ready <= (state_d == S_WAIT_START) || (state_d == S_IDLE) || (state_d == S_LOAD);
      case (state_q)
        S_IDLE: begin
          if (accept_in && input_data == MEASUREMENT_DATA_HEADER) begin
            byte_cnt_q <= '0;
`ifdef HELIOS_CYCLE_COUNTER_EN
            cyc_q      <= 16'h0000;
`endif
          end
        end
        S_LOAD: begin
          if (accept_in) begin
            for (int k = 0; k < LOAD_BYTES; k++) begin
              if (byte_cnt_q == BCW'(k)) meas_q[8*k +: 8] <= input_data;
            end
            byte_cnt_q <= byte_cnt_q + BCW'(1);
          end
        end
        S_INIT: begin
          for (int i = 0; i < NODES; i++) root_q[i] <= RW'(i);
          iter_q     <= 8'h00;
          send_idx_q <= '0;
`ifdef HELIOS_CYCLE_COUNTER_EN
          if (cyc_q != 16'hFFFF) cyc_q <= cyc_q + 16'd1;
`endif
        end
        S_ITERATE: begin
          for (int i = 0; i < NODES; i++) root_q[i] <= new_root[i];
          if (iter_q != 8'hFF) iter_q <= iter_q + 8'd1;
`ifdef HELIOS_CYCLE_COUNTER_EN
          if (cyc_q != 16'hFFFF) cyc_q <= cyc_q + 16'd1;
`endif
        end
        S_SEND: begin
          // Load the next byte whenever the output register is empty or being drained
          if (out_free) begin
            if (send_idx_q < SW'(FRAME_LEN)) begin
              output_data  <= frame_byte;
              output_valid <= 1'b1;
              send_idx_q   <= send_idx_q + SW'(1);
            end else begin
              output_valid <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_helios_single_fpga.sv
// Bench for helios_single_fpga: BFS cluster model plus directed frames with literal expectations.
`timescale 1ns/1ps
module tb_helios_single_fpga;
  localparam int unsigned GX = 4, GZ = 2, GU = 3, MW = 2;
  localparam int unsigned NN = GX * GZ, NB = (NN + 7) / 8, NA = 8 * NB;
  localparam int unsigned NODES = NN * GU, FLEN = 3 + GU;
  localparam logic [7:0] START = 8'h01, HDR = 8'h02;
`ifdef HELIOS_CYCLE_COUNTER_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] input_data;
  logic       input_valid;
  logic       input_ready;
  logic [7:0] output_data;
  logic       output_valid;
  logic       output_ready;

  always #5 clk = ~clk;

  helios_single_fpga dut (
    .clk(clk), .reset(reset),
    .input_data(input_data), .input_valid(input_valid), .input_ready(input_ready),
    .output_data(output_data), .output_valid(output_valid), .output_ready(output_ready)
  );

  int tests = 0;
  int fails = 0;
  byte unsigned exp_q[$];
  byte unsigned rx_q[$];
  int exp_iter;

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int mdist(input int a, input int b);
    int ax, az, au, bx, bz, bu;
    au = a / NN; ax = (a % NN) / GZ; az = (a % NN) % GZ;
    bu = b / NN; bx = (b % NN) / GZ; bz = (b % NN) % GZ;
    return ((ax > bx) ? ax - bx : bx - ax) + ((az > bz) ? az - bz : bz - az)
         + ((au > bu) ? au - bu : bu - au);
  endfunction

  // Components by BFS from each component's lowest index; the propagation needs as many
  // changing steps as the farthest hop distance to that minimum, plus one quiet step.
  function automatic void model(input logic [NA*GU-1:0] m);
    bit def [NODES];
    bit vis [NODES];
    int hop [NODES];
    int roots [GU];
    int q[$];
    int maxhop, it, cyc, v;
    maxhop = 0;
    for (int u = 0; u < GU; u++) roots[u] = 0;
    for (int i = 0; i < NODES; i++) begin
      def[i] = m[(i % NN) + (i / NN) * NA];
      vis[i] = 1'b0;
      hop[i] = 0;
    end
    for (int i = 0; i < NODES; i++) begin
      if (def[i] && !vis[i]) begin
        roots[i / NN]++;
        vis[i] = 1'b1;
        q.push_back(i);
        while (q.size() > 0) begin
          v = q.pop_front();
          for (int w = 0; w < NODES; w++) begin
            if (def[w] && !vis[w] && mdist(v, w) <= MW) begin
              vis[w] = 1'b1;
              hop[w] = hop[v] + 1;
              if (hop[w] > maxhop) maxhop = hop[w];
              q.push_back(w);
            end
          end
        end
      end
    end
    it  = (maxhop + 1 > 255) ? 255 : maxhop + 1;
    cyc = it + 1;
    exp_iter = it;
    exp_q.push_back(8'(it));
    exp_q.push_back(CNT_EN ? 8'(cyc >> 8) : 8'h00);
    exp_q.push_back(CNT_EN ? 8'(cyc) : 8'h00);
    for (int u = 0; u < GU; u++) exp_q.push_back((roots[u] > 255) ? 8'hFF : 8'(roots[u]));
  endfunction

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    input_data  = b;
    input_valid = 1'b1;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      if (input_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end
    end
    input_valid = 1'b0;
    check("input_accept", int'(done), 1);
  endtask

  task automatic run_shot(input logic [NA*GU-1:0] m, input bit stall);
    int lat;
    bit seen;
    rx_q.delete();
    model(m);
    send_byte(HDR);
    for (int k = 0; k < NB * GU; k++) send_byte(m[8*k +: 8]);
    check("busy_input_ready", int'(input_ready), 0);
    lat = 0;
    seen = 1'b0;
    for (int k = 0; k < 400 && !seen; k++) begin
      @(posedge clk);
      #1;
      lat++;
      if (output_valid) seen = 1'b1;
    end
    check("latency", lat, exp_iter + 2);
    if (stall) begin
      for (int k = 0; k < 400 && rx_q.size() < 2; k++) begin
        @(posedge clk);
        #1;
      end
      output_ready = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      output_ready = 1'b1;
    end
    for (int k = 0; k < 400 && rx_q.size() < FLEN; k++) begin
      @(posedge clk);
      #1;
    end
    check("frame_len", rx_q.size(), FLEN);
    check("valid_after_frame", int'(output_valid), 0);
    check("expected_left", exp_q.size(), 0);
  endtask

  task automatic check_lit(input string name, input int e0, input int e1, input int e2,
                           input int e3, input int e4, input int e5);
    int ev [6];
    ev = '{e0, e1, e2, e3, e4, e5};
    for (int i = 0; i < 6; i++)
      check($sformatf("%s[%0d]", name, i), (rx_q.size() > i) ? int'(rx_q[i]) : -1, ev[i]);
  endtask

  initial begin
    reset        = 1'b1;
    input_data   = 8'h00;
    input_valid  = 1'b0;
    output_ready = 1'b1;

    // Output monitor: every accepted byte against the model, every stall for stability
    fork
      begin
        bit held_pending;
        logic [7:0] held_data;
        held_pending = 1'b0;
        held_data = 8'h00;
        forever begin
          @(negedge clk);
          if (reset) begin
            held_pending = 1'b0;
          end else begin
            if (held_pending) begin
              check("held_valid", int'(output_valid), 1);
              check("held_data", int'(output_data), int'(held_data));
            end
            held_pending = 1'b0;
            if (output_valid) begin
              if (output_ready) begin
                if (exp_q.size() == 0) check("unexpected_byte", int'(output_data), -1);
                else check("frame_byte", int'(output_data), int'(exp_q.pop_front()));
                rx_q.push_back(output_data);
              end else begin
                held_pending = 1'b1;
                held_data = output_data;
              end
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_input_ready", int'(input_ready), 0);
    check("rst_output_valid", int'(output_valid), 0);
    check("rst_output_data", int'(output_data), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    send_byte(HDR);
    send_byte(START);
    send_byte(8'h33);

    run_shot(24'h000010, 1'b0);
    check_lit("single", 1, 0, CNT_EN ? 2 : 0, 1, 0, 0);
    run_shot(24'h000000, 1'b0);
    check_lit("empty", 1, 0, CNT_EN ? 2 : 0, 0, 0, 0);
    run_shot(24'h000005, 1'b0);
    check_lit("pair", 2, 0, CNT_EN ? 3 : 0, 1, 0, 0);
    run_shot(24'h800001, 1'b0);
    check_lit("far", 1, 0, CNT_EN ? 2 : 0, 1, 0, 1);
    run_shot(24'h8118C3, 1'b1);
    run_shot(24'hFFFFFF, 1'b0);
    run_shot(24'h410824, 1'b0);
    run_shot(24'h020102, 1'b0);

    // Abort mid-load, then re-arm
    send_byte(HDR);
    send_byte(8'hFF);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check("midload_rst_ready", int'(input_ready), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    send_byte(8'h10);
    send_byte(START);
    send_byte(8'h05);
    run_shot(24'h000010, 1'b0);
    check_lit("after_reset", 1, 0, CNT_EN ? 2 : 0, 1, 0, 0);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
